// File: rtl/dcache_resp.sv
// Direct-mapped, write-through / no-write-allocate data cache front end.
// Loads hit in one cycle; misses refill a full line word by word from backing memory.
package dcache_resp_pkg;
  typedef enum logic [2:0] {
    L_S_BYTE   = 3'd0,
    L_S_HALF   = 3'd1,
    L_S_WORD   = 3'd2,
    L_S_BYTE_U = 3'd3,
    L_S_HALF_U = 3'd4
  } l_s_sel_t;
endpackage

module dcache_resp
  import dcache_resp_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_val,
  input  l_s_sel_t    i_l_s_sel,
  output logic [31:0] o_rd_val,
  output logic        o_rd_valid,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  localparam int WI_W    = $clog2(WORDS);
  localparam int LI_W    = $clog2(LINES);
  localparam int TAG_LSB = 2 + WI_W + LI_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int IDX_W   = LI_W + WI_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  function automatic logic misalign_f(input l_s_sel_t sel, input logic [1:0] off);
    case (sel)
      L_S_HALF, L_S_HALF_U: misalign_f = off[0];
      L_S_WORD:             misalign_f = (off != 2'b00);
      default:              misalign_f = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_f(input l_s_sel_t sel, input logic [1:0] off);
    case (sel)
      L_S_BYTE, L_S_BYTE_U: wstrb_f = 4'b0001 << off;
      L_S_HALF, L_S_HALF_U: wstrb_f = 4'b0011 << off;
      default:              wstrb_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input l_s_sel_t sel, input logic [31:0] val,
                                          input logic [1:0] off);
    case (sel)
      L_S_BYTE, L_S_BYTE_U: wdata_f = {24'b0, val[7:0]} << {off, 3'b000};
      L_S_HALF, L_S_HALF_U: wdata_f = {16'b0, val[15:0]} << {off, 3'b000};
      default:              wdata_f = val;
    endcase
  endfunction

  state_t            state_q;
  logic [31:0]       req_addr_q;
  logic [WI_W-1:0]   cnt_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [31:0]       data_mem [LINES*WORDS];

  logic [31:0]       rd_val_q;
  logic              rd_valid_q;
  logic              misalign_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic [1:0]        in_off;
  logic [WI_W-1:0]   in_word;
  logic [LI_W-1:0]   in_line;
  logic [TAG_W-1:0]  in_tag;
  logic [1:0]        req_off;
  logic [WI_W-1:0]   req_word;
  logic [LI_W-1:0]   req_line;
  logic [TAG_W-1:0]  req_tag;

  assign in_off   = i_addr[1:0];
  assign in_word  = i_addr[2 +: WI_W];
  assign in_line  = i_addr[2+WI_W +: LI_W];
  assign in_tag   = i_addr[31:TAG_LSB];
  assign req_off  = req_addr_q[1:0];
  assign req_word = req_addr_q[2 +: WI_W];
  assign req_line = req_addr_q[2+WI_W +: LI_W];
  assign req_tag  = req_addr_q[31:TAG_LSB];

  logic        hit;
  logic [31:0] hit_word;
  logic        req_mis;
  logic        idle_mis;
  logic        idle_st;
  logic        idle_ld;
  logic        ack_v;

  assign hit      = valid_q[in_line] && (tag_mem[in_line] == in_tag);
  assign hit_word = data_mem[{in_line, in_word}];
  assign req_mis  = misalign_f(i_l_s_sel, in_off);
  // A simultaneous load and store is treated as the store alone.
  assign idle_mis = (state_q == IDLE) && (i_rd_en || i_wr_en) && req_mis;
  assign idle_st  = (state_q == IDLE) && i_wr_en && !req_mis;
  assign idle_ld  = (state_q == IDLE) && i_rd_en && !i_wr_en && !req_mis;
  assign ack_v    = mem_req_q && i_mem_ack;

  always_comb begin
    o_stall = 1'b0;
    case (state_q)
      IDLE:    o_stall = idle_st || (idle_ld && !hit);
      WRITE:   o_stall = !ack_v;
      default: o_stall = 1'b1;
    endcase
  end

  logic             arr_we_d;
  logic [IDX_W-1:0] arr_idx_d;
  logic [31:0]      arr_wdata_d;
  logic [3:0]       arr_be_d;
  logic             tag_we_d;

  always_comb begin
    arr_we_d    = 1'b0;
    arr_idx_d   = {in_line, in_word};
    arr_wdata_d = wdata_f(i_l_s_sel, i_wr_val, in_off);
    arr_be_d    = wstrb_f(i_l_s_sel, in_off);
    tag_we_d    = 1'b0;
    if (idle_st && hit) begin
      arr_we_d = 1'b1;
    end else if (state_q == REFILL && ack_v) begin
      arr_we_d    = 1'b1;
      arr_idx_d   = {req_line, cnt_q};
      arr_wdata_d = i_mem_rdata;
      arr_be_d    = 4'b1111;
      tag_we_d    = (cnt_q == WI_W'(WORDS - 1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (arr_we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (arr_be_d[b]) data_mem[arr_idx_d][8*b +: 8] <= arr_wdata_d[8*b +: 8];
      end
    end
    if (tag_we_d) tag_mem[req_line] <= req_tag;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      rd_val_q    <= '0;
      rd_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_mis) begin
            misalign_q <= 1'b1;
          end else if (idle_st) begin
            state_q     <= WRITE;
            req_addr_q  <= i_addr;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {i_addr[31:2], 2'b00};
            mem_wdata_q <= wdata_f(i_l_s_sel, i_wr_val, in_off);
            mem_wstrb_q <= wstrb_f(i_l_s_sel, in_off);
          end else if (idle_ld && hit) begin
            rd_valid_q <= 1'b1;
            rd_val_q   <= hit_word >> {in_off, 3'b000};
          end else if (idle_ld) begin
            state_q     <= REFILL;
            req_addr_q  <= i_addr;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_addr_q  <= {i_addr[31:2+WI_W], {WI_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          // One word in flight at a time; request drops for a cycle between words.
          if (ack_v) begin
            mem_req_q <= 1'b0;
            if (cnt_q == WI_W'(WORDS - 1)) begin
              cnt_q             <= '0;
              valid_q[req_line] <= 1'b1;
              state_q           <= RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {req_addr_q[31:2+WI_W], cnt_q, 2'b00};
          end
        end
        WRITE: begin
          if (ack_v) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            state_q     <= IDLE;
          end
        end
        RESP: begin
          rd_valid_q <= 1'b1;
          rd_val_q   <= data_mem[{req_line, req_word}] >> {req_off, 3'b000};
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rd_val    = rd_val_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_misalign  = misalign_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
endmodule
